// File: rtl/button_cmd_pulser_pkg.sv
`default_nettype none
// ============================================================================
// button_cmd_pulser_pkg
// Command indices, default timing and the priority helper for the pulser.
// Revision: 1.0
// ============================================================================
package button_cmd_pulser_pkg;

  localparam int CMD_LD1  = 0;
  localparam int CMD_LD2  = 1;
  localparam int CMD_UP   = 2;
  localparam int CMD_DOWN = 3;
  localparam int NUM_CMDS = 4;

  localparam int DEF_DEB_CYCLES = 100000;
  localparam int DEF_REP_DELAY  = 50000000;
  localparam int DEF_REP_RATE   = 10000000;
  localparam int DEF_CNT_W      = 27;

  typedef logic [NUM_CMDS-1:0] cmd_vec_t;

  // Lowest index wins, which gives Ld_1 > Ld_2 > up > down.
  function automatic cmd_vec_t lowest_set(input cmd_vec_t v);
    return v & (~v + cmd_vec_t'(1));
  endfunction

endpackage : button_cmd_pulser_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce
// 2-FF synchroniser followed by a stable-sample counter on one raw button.
// Revision: 1.0
// ============================================================================
module btn_debounce
  import button_cmd_pulser_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_last) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/button_cmd_pulser.sv
`default_nettype none
// ============================================================================
// button_cmd_pulser
// Debounced push-buttons to one-hot counter command strobes with auto-repeat.
// Revision: 1.0
// ============================================================================
module button_cmd_pulser
  import button_cmd_pulser_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_RATE   = DEF_REP_RATE,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_ld1,
  input  logic btn_ld2,
  output logic up,
  output logic down,
  output logic Ld_1,
  output logic Ld_2,
  output logic EN
);

  cmd_vec_t   w_raw;
  cmd_vec_t   w_lvl;
  cmd_vec_t   r_lvl_d;
  cmd_vec_t   w_press;
  cmd_vec_t   w_ev;
  cmd_vec_t   r_cmd;
  logic       r_en;
  logic [1:0] w_rep;
  logic       w_both;

  assign w_raw[CMD_LD1]  = btn_ld1;
  assign w_raw[CMD_LD2]  = btn_ld2;
  assign w_raw[CMD_UP]   = btn_up;
  assign w_raw[CMD_DOWN] = btn_down;

  for (genvar i = 0; i < NUM_CMDS; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (w_raw[i]),
      .level (w_lvl[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lvl_d <= '0;
    else      r_lvl_d <= w_lvl;
  end

  assign w_press = w_lvl & ~r_lvl_d;
  assign w_both  = w_lvl[CMD_UP] & w_lvl[CMD_DOWN];

  // Timer 0 means idle; it starts the first cycle its button is the only one
  // of up/down held, so a press and a partner release both get a full delay.
  for (genvar i = 0; i < 2; i++) begin : g_rep
    localparam int IDX = CMD_UP + i;
    localparam logic [CNT_W-1:0] c_delay  = CNT_W'(REP_DELAY);
    localparam logic [CNT_W-1:0] c_reload = CNT_W'(REP_DELAY - REP_RATE + 1);

    logic [CNT_W-1:0] r_tmr;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                            r_tmr <= '0;
      else if (!w_lvl[IDX] || w_both)      r_tmr <= '0;
      else if (r_tmr == '0)                r_tmr <= CNT_W'(1);
      else if (r_tmr == c_delay)           r_tmr <= c_reload;
      else                                 r_tmr <= r_tmr + CNT_W'(1);
    end

    assign w_rep[i] = w_lvl[IDX] & ~w_both & (r_tmr == c_delay);
  end

  always_comb begin
    w_ev           = w_press;
    w_ev[CMD_UP]   = w_press[CMD_UP]   | w_rep[0];
    w_ev[CMD_DOWN] = w_press[CMD_DOWN] | w_rep[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd <= '0;
      r_en  <= 1'b0;
    end else begin
      r_cmd <= lowest_set(w_ev);
      r_en  <= |w_ev;
    end
  end

  assign Ld_1 = r_cmd[CMD_LD1];
  assign Ld_2 = r_cmd[CMD_LD2];
  assign up   = r_cmd[CMD_UP];
  assign down = r_cmd[CMD_DOWN];
  assign EN   = r_en;

endmodule : button_cmd_pulser
`default_nettype wire

// File: tb/tb_button_cmd_pulser.sv
`default_nettype none
// ============================================================================
// tb_button_cmd_pulser
// Directed cycle-by-cycle checks of strobe timing, repeat and arbitration.
// Revision: 1.0
// ============================================================================
module tb_button_cmd_pulser;

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_LD1  = 4'b0001;
  localparam logic [3:0] C_LD2  = 4'b0010;
  localparam logic [3:0] C_UP   = 4'b0100;
  localparam logic [3:0] C_DN   = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  logic btn_up, btn_down, btn_ld1, btn_ld2;
  logic up, down, Ld_1, Ld_2, EN;

  int n_cmp = 0;
  int n_err = 0;

  button_cmd_pulser #(
    .DEB_CYCLES (4),
    .REP_DELAY  (20),
    .REP_RATE   (5),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_ld1  (btn_ld1),
    .btn_ld2  (btn_ld2),
    .up       (up),
    .down     (down),
    .Ld_1     (Ld_1),
    .Ld_2     (Ld_2),
    .EN       (EN)
  );

  always #5 clk = ~clk;

  // Observed and expected are packed as {EN, down, up, Ld_2, Ld_1}.
  task automatic cmp(input logic [3:0] cmd, input string tag, input int k);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {EN, down, up, Ld_2, Ld_1};
    exp = {|cmd, cmd};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d got=%b exp=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chk(input logic [3:0] cmd, input string tag, input int k);
    @(negedge clk);
    cmp(cmd, tag, k);
  endtask

  task automatic idle(input int n);
    btn_up = 0; btn_down = 0; btn_ld1 = 0; btn_ld2 = 0;
    for (int i = 0; i < n; i++) chk(C_NONE, "idle", i);
  endtask

  initial begin
    rst = 0; btn_up = 0; btn_down = 0; btn_ld1 = 0; btn_ld2 = 0;
    chk(C_NONE, "reset", 0);
    chk(C_NONE, "reset", 1);
    rst = 1;
    idle(3);

    // 1: bouncing up, then held from k=0 -> single strobe at 6
    for (int k = 0; k < 12; k++) begin
      btn_up = ((k / 2) % 2) == 0;
      chk(C_NONE, "t1_bounce", k);
    end
    for (int k = 0; k < 25; k++) begin
      btn_up = (k < 15);
      chk((k == 6) ? C_UP : C_NONE, "t1_press", k);
    end
    idle(3);

    // 2: down held 50 cycles -> press + repeats
    for (int k = 0; k < 65; k++) begin
      btn_down = (k < 50);
      chk((k == 6 || k == 26 || k == 31 || k == 36 || k == 41 || k == 46 || k == 51)
          ? C_DN : C_NONE, "t2_down_rep", k);
    end
    idle(3);

    // 3: ld1 and up together -> Ld_1 wins, up still repeats
    for (int k = 0; k < 50; k++) begin
      btn_ld1 = (k < 40);
      btn_up  = (k < 40);
      chk((k == 6) ? C_LD1 :
          (k == 26 || k == 31 || k == 36 || k == 41) ? C_UP : C_NONE, "t3_ld1_up", k);
    end
    idle(3);

    // 4: up and down together -> up only, repeat after down released
    for (int k = 0; k < 111; k++) begin
      btn_up   = (k < 100);
      btn_down = (k < 60);
      chk((k == 6 || k == 86 || k == 91 || k == 96 || k == 101) ? C_UP : C_NONE,
          "t4_up_down", k);
    end
    idle(3);

    // 5: short ld2 pulse is filtered
    for (int k = 0; k < 15; k++) begin
      btn_ld2 = (k < 3);
      chk(C_NONE, "t5_short_ld2", k);
    end
    idle(3);

    // 7: ld2 beats a simultaneous down press
    for (int k = 0; k < 20; k++) begin
      btn_ld2  = (k < 10);
      btn_down = (k < 10);
      chk((k == 6) ? C_LD2 : C_NONE, "t7_ld2_down", k);
    end
    idle(3);

    // 6: reset mid-repeat with up held
    for (int k = 0; k < 32; k++) begin
      btn_up = 1;
      chk((k == 6 || k == 26 || k == 31) ? C_UP : C_NONE, "t6_before_rst", k);
    end
    #2 rst = 0;
    #1 cmp(C_NONE, "t6_async_rst", 0);
    for (int j = 0; j < 3; j++) chk(C_NONE, "t6_in_rst", j);
    rst = 1;
    for (int m = 0; m < 46; m++) begin
      btn_up = (m < 39);
      chk((m == 6 || m == 26 || m == 31 || m == 36 || m == 41) ? C_UP : C_NONE,
          "t6_after_rst", m);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_button_cmd_pulser
`default_nettype wire
